// File: rtl/msb_arbiter_ctrl_if.sv
// Request/grant bundle between the render-resource requesters and the MSB-first arbiter.
interface msb_arbiter_ctrl_if;
  logic [5:0] req;
  logic       rr_en;
  logic       done;
  logic [5:0] grant;
  logic [2:0] grant_id;
  logic       busy;
  logic       timeout;

  modport master (
    output req, rr_en, done,
    input  grant, grant_id, busy, timeout
  );

  modport slave (
    input  req, rr_en, done,
    output grant, grant_id, busy, timeout
  );
endinterface

// File: rtl/msb_arbiter_ctrl.sv
// Six-way arbiter for the shared render resource: fixed MSB-first or rotating priority,
// with a bounded hold time and a one-cycle turnaround between owners.
//
// state | meaning
// IDLE  | no owner, arbitrate when any req is set
// OWN   | grant held until done, abort or hold limit
// GAP   | one turnaround cycle, grant low, no arbitration
module msb_arbiter_ctrl #(
  parameter int unsigned MAX_HOLD = 64
) (
  input logic               clk,
  input logic               rst_n,
  msb_arbiter_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t     state_q, state_d;
  logic [5:0] grant_q, grant_d;
  logic [2:0] gid_q, gid_d;
  logic [2:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  logic [2:0] fixed_idx, rot_idx, rot_top, win_idx;
  logic       hold_limit;

  function automatic logic [2:0] wrap_down(input logic [2:0] top, input int k);
    int j;
    j = int'(top) - k;
    if (j < 0) j = j + 6;
    return 3'(j);
  endfunction

  always_comb begin
    fixed_idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (bus.req[i]) fixed_idx = 3'(i);
    end
  end

  // Scan from lowest to highest priority so the last hit is the winner.
  assign rot_top = (last_q == 3'd0) ? 3'd5 : last_q - 3'd1;
  always_comb begin
    rot_idx = 3'd0;
    for (int k = 5; k >= 0; k--) begin
      if (bus.req[wrap_down(rot_top, k)]) rot_idx = wrap_down(rot_top, k);
    end
  end

  assign win_idx    = bus.rr_en ? rot_idx : fixed_idx;
  assign hold_limit = (hold_q == 8'(MAX_HOLD - 1));

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gid_d     = gid_q;
    last_d    = last_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_d = 6'(6'b000001 << win_idx);
          gid_d   = win_idx;
          last_d  = win_idx;
          hold_d  = 8'd0;
          state_d = OWN;
        end
      end
      OWN: begin
        if (bus.done || !bus.req[gid_q] || hold_limit) begin
          state_d   = GAP;
          grant_d   = 6'd0;
          gid_d     = 3'd0;
          // done and abort both take precedence over a hold-limit release
          timeout_d = !bus.done && bus.req[gid_q];
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      GAP: state_d = IDLE;
      default: begin
        state_d = IDLE;
        grant_d = 6'd0;
        gid_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 6'd0;
      gid_q     <= 3'd0;
      last_q    <= 3'd0;
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gid_q     <= gid_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = (state_q == OWN);
  assign bus.timeout  = timeout_q;
endmodule
